// File: rtl/tv_b_gone_trigger_pkg.sv
// Shared types and 12 MHz board defaults for the tv_b_gone push-button front-end.
// The optional LED blink modes (TV_B_GONE_TRIGGER_BLINK_EN) use led_mode_t.
package tv_b_gone_trigger_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      HOLD      = 2'd1,
      LONG_REL  = 2'd2,
      START_REQ = 2'd3
   } trigger_state_t;

   typedef enum logic [1:0] {
      LED_OFF   = 2'd0,
      LED_SOLID = 2'd1,
      LED_LOOP  = 2'd2,
      LED_ERR   = 2'd3
   } led_mode_t;

   localparam int DEF_CNT_WIDTH            = 24;
   localparam int DEF_DEBOUNCE_CYCLES      = 120000;    // 10 ms
   localparam int DEF_LONG_PRESS_CYCLES    = 12000000;  // 1 s
   localparam int DEF_START_TIMEOUT_CYCLES = 1200000;   // 100 ms
   localparam int DEF_BLINK_HALF_CYCLES    = 3000000;   // 250 ms

   // Cycle counts must fit the counters and leave room for a "last" value.
   function automatic bit param_ok(int value, int width);
      return (value >= 2) && (longint'(value) < (longint'(1) << width));
   endfunction

endpackage

// File: rtl/tv_b_gone_trigger_if.sv
// Button / core-control bundle between the trigger front-end (master) and its surroundings (slave).
interface tv_b_gone_trigger_if;
   logic btn_in;
   logic busy_in;
   logic start_out;
   logic loop_forever_out;
   logic error_out;
   logic status_led_out;

   // start_out is a level request: it stays high until busy_in is sampled high
   // (dropped the following cycle) or the acknowledge timeout expires.
   modport master (
      input  btn_in, busy_in,
      output start_out, loop_forever_out, error_out, status_led_out
   );

   modport slave (
      output btn_in, busy_in,
      input  start_out, loop_forever_out, error_out, status_led_out
   );
endinterface

// File: rtl/tv_b_gone_trigger_sync_debounce.sv
// Two-flop synchronizer plus counting debouncer for the raw button; emits one-cycle
// rise/fall pulses of the debounced level.
module trigger_sync_debounce
   import tv_b_gone_trigger_pkg::*;
#(
   parameter int CNT_WIDTH       = DEF_CNT_WIDTH,
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
   input  logic clock_in,
   input  logic reset_in,
   input  logic btn_in,
   output logic rise,
   output logic fall
);

   localparam logic [CNT_WIDTH-1:0] DEB_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

   logic                 sync1;
   logic                 sync2;
   logic                 level;
   logic                 level_prev;
   logic [CNT_WIDTH-1:0] cnt;

   // cnt counts consecutive cycles the synchronized input disagrees with level.
   always_ff @(posedge clock_in) begin
      if (reset_in) begin
         sync1      <= 1'b0;
         sync2      <= 1'b0;
         level      <= 1'b0;
         level_prev <= 1'b0;
         cnt        <= '0;
      end else begin
         sync1      <= btn_in;
         sync2      <= sync1;
         level_prev <= level;
         if (sync2 == level) begin
            cnt <= '0;
         end else if (cnt == DEB_LAST) begin
            level <= sync2;
            cnt   <= '0;
         end else begin
            cnt <= cnt + CNT_WIDTH'(1);
         end
      end
   end

   assign rise = level & ~level_prev;
   assign fall = ~level & level_prev;

endmodule

// File: rtl/tv_b_gone_trigger.sv
// Push-button front-end for tv_b_gone: short press = one sweep, long press = toggle loop mode.
// Define TV_B_GONE_TRIGGER_BLINK_EN for blinking status LED modes (default: LED = busy | error).
module tv_b_gone_trigger
   import tv_b_gone_trigger_pkg::*;
#(
   parameter int CNT_WIDTH            = DEF_CNT_WIDTH,
   parameter int DEBOUNCE_CYCLES      = DEF_DEBOUNCE_CYCLES,
   parameter int LONG_PRESS_CYCLES    = DEF_LONG_PRESS_CYCLES,
   parameter int START_TIMEOUT_CYCLES = DEF_START_TIMEOUT_CYCLES,
   parameter int BLINK_HALF_CYCLES    = DEF_BLINK_HALF_CYCLES
) (
   input  logic                  clock_in,
   input  logic                  reset_in,
   tv_b_gone_trigger_if.master   bus,
   output trigger_state_t        state_dbg
);

   if (!param_ok(DEBOUNCE_CYCLES, CNT_WIDTH) || !param_ok(LONG_PRESS_CYCLES, CNT_WIDTH) ||
       !param_ok(START_TIMEOUT_CYCLES, CNT_WIDTH) || !param_ok(BLINK_HALF_CYCLES, CNT_WIDTH)) begin : g_param_check
      $error("tv_b_gone_trigger: cycle parameters must be >= 2 and < 2**CNT_WIDTH");
   end

   localparam logic [CNT_WIDTH-1:0] LONG_LAST = CNT_WIDTH'(LONG_PRESS_CYCLES - 1);
   localparam logic [CNT_WIDTH-1:0] TO_LAST   = CNT_WIDTH'(START_TIMEOUT_CYCLES - 1);

   logic                 rise;
   logic                 fall;
   trigger_state_t       state;
   logic [CNT_WIDTH-1:0] hold_cnt;
   logic [CNT_WIDTH-1:0] to_cnt;
   logic                 start_q;
   logic                 loop_q;
   logic                 error_q;
   logic                 led_q;

   trigger_sync_debounce #(
      .CNT_WIDTH       (CNT_WIDTH),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) u_sync_debounce (
      .clock_in (clock_in),
      .reset_in (reset_in),
      .btn_in   (bus.btn_in),
      .rise     (rise),
      .fall     (fall)
   );

   always_ff @(posedge clock_in) begin
      if (reset_in) begin
         state    <= IDLE;
         hold_cnt <= '0;
         to_cnt   <= '0;
         start_q  <= 1'b0;
         loop_q   <= 1'b0;
         error_q  <= 1'b0;
      end else begin
         if (rise && state != START_REQ) error_q <= 1'b0;
         case (state)
            IDLE: begin
               if (rise) begin
                  state    <= HOLD;
                  hold_cnt <= '0;
               end
            end
            HOLD: begin
               if (hold_cnt != '1) hold_cnt <= hold_cnt + CNT_WIDTH'(1);
               if (fall && hold_cnt < LONG_LAST) begin
                  if (!bus.busy_in) begin
                     state   <= START_REQ;
                     start_q <= 1'b1;
                     to_cnt  <= '0;
                  end else begin
                     // Busy core in loop mode: dropping loop lets it finish the current sweep.
                     loop_q <= 1'b0;
                     state  <= IDLE;
                  end
               end else if (fall) begin
                  // Release on the very cycle the long threshold is reached: toggle and release together.
                  loop_q <= ~loop_q;
                  if (!loop_q && !bus.busy_in) begin
                     state   <= START_REQ;
                     start_q <= 1'b1;
                     to_cnt  <= '0;
                  end else begin
                     state <= IDLE;
                  end
               end else if (hold_cnt == LONG_LAST) begin
                  loop_q <= ~loop_q;
                  state  <= LONG_REL;
               end
            end
            LONG_REL: begin
               if (fall) begin
                  if (loop_q && !bus.busy_in) begin
                     state   <= START_REQ;
                     start_q <= 1'b1;
                     to_cnt  <= '0;
                  end else begin
                     state <= IDLE;
                  end
               end
            end
            START_REQ: begin
               if (bus.busy_in) begin
                  start_q <= 1'b0;
                  state   <= IDLE;
               end else if (to_cnt == TO_LAST) begin
                  start_q <= 1'b0;
                  error_q <= 1'b1;
                  loop_q  <= 1'b0;
                  state   <= IDLE;
               end else begin
                  to_cnt <= to_cnt + CNT_WIDTH'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef TV_B_GONE_TRIGGER_BLINK_EN
   if (BLINK_HALF_CYCLES / 4 < 1) begin : g_blink_check
      $error("tv_b_gone_trigger: BLINK_HALF_CYCLES must be >= 4");
   end

   localparam logic [CNT_WIDTH-1:0] LOOP_LAST = CNT_WIDTH'(BLINK_HALF_CYCLES - 1);
   localparam logic [CNT_WIDTH-1:0] ERR_LAST  = CNT_WIDTH'(BLINK_HALF_CYCLES / 4 - 1);

   led_mode_t            mode;
   led_mode_t            mode_q;
   logic [CNT_WIDTH-1:0] blink_cnt;
   logic [CNT_WIDTH-1:0] blink_last;

   always_comb begin
      mode = LED_OFF;
      if (bus.busy_in)  mode = LED_SOLID;
      else if (error_q) mode = LED_ERR;
      else if (loop_q)  mode = LED_LOOP;
   end

   assign blink_last = (mode == LED_ERR) ? ERR_LAST : LOOP_LAST;

   // Every mode change restarts the blink phase with the LED on.
   always_ff @(posedge clock_in) begin
      if (reset_in) begin
         led_q     <= 1'b0;
         mode_q    <= LED_OFF;
         blink_cnt <= '0;
      end else if (mode != mode_q) begin
         mode_q    <= mode;
         blink_cnt <= '0;
         led_q     <= (mode != LED_OFF);
      end else if (mode == LED_LOOP || mode == LED_ERR) begin
         if (blink_cnt == blink_last) begin
            blink_cnt <= '0;
            led_q     <= ~led_q;
         end else begin
            blink_cnt <= blink_cnt + CNT_WIDTH'(1);
         end
      end
   end
`else
   always_ff @(posedge clock_in) begin
      if (reset_in) led_q <= 1'b0;
      else          led_q <= bus.busy_in | error_q;
   end
`endif

   assign bus.start_out        = start_q;
   assign bus.loop_forever_out = loop_q;
   assign bus.error_out        = error_q;
   assign bus.status_led_out   = led_q;
   assign state_dbg            = state;

endmodule

// File: doc/tv_b_gone_trigger.md
Name: tv_b_gone_trigger

Overview:
- Upstream front-end for tv_b_gone. Converts one raw push-button into the `start_in` and `loop_forever_in` controls, and drives a status LED.
- Short press requests a single sweep. Long press toggles loop mode.
- `start_out` uses a handshake against the core's `busy_out`. It is held high until the core acknowledges, so the pulse always survives the core's internal debouncer.
- Start-acknowledge timeout is reported on `error_out`.

Parameters:
- CNT_WIDTH, 24, width of all internal counters.
- DEBOUNCE_CYCLES, 120000, number of consecutive stable synchronized cycles before the debounced level changes.
- LONG_PRESS_CYCLES, 12000000, hold duration (counted from the debounced rise) that classifies a press as long.
- START_TIMEOUT_CYCLES, 1200000, maximum cycles `start_out` stays high waiting for `busy_in`.
- BLINK_HALF_CYCLES, 3000000, LED blink half-period (optional feature only).

Ports:
- clock_in  in  1  single clock; all logic on rising edge.
- reset_in  in  1  synchronous, active-high reset.
- btn_in  in  1  raw button, active high, asynchronous to clock_in.
- busy_in  in  1  from tv_b_gone busy_out.
- start_out  out  1  to tv_b_gone start_in.
- loop_forever_out  out  1  to tv_b_gone loop_forever_in.
- error_out  out  1  sticky start-timeout flag.
- status_led_out  out  1  status LED drive, active high.

Behaviour:
- Reset: all outputs 0, FSM in IDLE, all counters 0, synchronizer flops 0, debounced level 0. Reset mid-operation aborts any request immediately; `start_out` is low on the first cycle after reset.
- Input path: 2-flop synchronizer, then debouncer. The debounced level takes the synchronized value on the cycle after that value has differed from it for DEBOUNCE_CYCLES consecutive cycles. Any glitch restarts the count.
- Press edge: one-cycle rise/fall pulses are derived from the debounced level. A rise clears `error_out`.
- FSM states: IDLE, HOLD, LONG_REL, START_REQ.
- IDLE:
  - debounced rise → HOLD; hold counter cleared to 0.
- HOLD:
  - Hold counter increments each cycle and saturates.
  - Fall with counter < LONG_PRESS_CYCLES-1 is a short press:
    - if busy_in=0 → START_REQ;
    - else if loop_forever_out=1 → clear loop_forever_out (core finishes its current sweep), then IDLE;
    - else → ignored, IDLE.
  - Counter reaching LONG_PRESS_CYCLES-1 while still held → toggle loop_forever_out on that cycle, then LONG_REL.
- LONG_REL:
  - wait for fall;
  - then if loop_forever_out=1 and busy_in=0 → START_REQ;
  - else → IDLE.
- START_REQ:
  - `start_out`=1 and the timeout counter runs.
  - busy_in=1 seen → next cycle `start_out`=0, IDLE.
  - Counter reaching START_TIMEOUT_CYCLES-1 with no busy → `start_out`=0, `error_out`=1, loop_forever_out=0, IDLE.
  - busy wins if it arrives on the same cycle as the timeout.
  - Button edges are ignored in START_REQ.
- busy_in already high on entry to START_REQ: this cannot occur, because the entry conditions check busy_in=0.
- Counters: unsigned CNT_WIDTH, saturating, never wrap. Parameters must be ≥2 and < 2^CNT_WIDTH; this is checked by an elaboration assertion.
- Without the optional feature, status_led_out = busy_in | error_out (registered, 1-cycle latency).

Optional Feature:
- Macro: TV_B_GONE_TRIGGER_BLINK_EN.
- Defined:
  - status_led_out is solid on while busy_in=1;
  - toggles every BLINK_HALF_CYCLES while loop_forever_out=1 and busy_in=0;
  - toggles every BLINK_HALF_CYCLES/4 while error_out=1 (error takes priority);
  - otherwise 0.
  - The blink counter resets whenever the mode changes. The LED always starts in the on phase.
- Undefined: the blink counter and BLINK_HALF_CYCLES logic are absent, and the LED follows the base rule above.

Decomposition:
- Package tv_b_gone_trigger_pkg holds:
  - trigger_state_t enum (IDLE, HOLD, LONG_REL, START_REQ, 2-bit);
  - default cycle constants for the 12 MHz board clock.
- Sub-module trigger_sync_debounce contains the synchronizer, debouncer and rise/fall pulse outputs, parameterised by DEBOUNCE_CYCLES/CNT_WIDTH.
- FSM, loop and error logic stay in the top module.

Test Plan (DEBOUNCE=4, LONG=20, TIMEOUT=10, BLINK=8):
- Reset, then btn high for 10 cycles then low, busy_in rising 3 cycles after start_out → start_out high exactly until the cycle after busy_in=1; loop_forever_out stays 0.
- btn held 40 cycles, busy_in=0, core acks → loop_forever_out toggles to 1 about 20 cycles after the debounced rise; start_out asserts after release.
- With loop=1 and busy_in=1, short press → loop_forever_out=0; start_out never asserts.
- Short press, busy_in never rises → start_out low after 10 cycles; error_out=1; next debounced rise clears error_out.
- 1–3-cycle btn glitches repeated → debounced level never changes; no output activity.
- reset_in pulsed mid-START_REQ → next cycle all outputs 0, FSM IDLE. Under TV_B_GONE_TRIGGER_BLINK_EN with loop=1, busy=0, the LED period is 16 cycles.
